apb_slave_regfile: RTL and testbench
====================================

Name: apb_slave_regfile

Overview:
- APB responder that terminates transfers from the APB master side of the AHB-to-APB bridge.
- Holds a bank of NUM_REGS DATA_WIDTH-bit registers; register 0 is a read-only ID.
- Inserts a programmable number of wait states through PREADY.
- Flags illegal accesses on PSLVERR: out-of-range address, or a write to the ID register.

Parameters:
- DATA_WIDTH, 16, width of PWDATA/PRDATA and of each register
- ADDR_WIDTH, 8, width of PADDR; PADDR is a register index (word address)
- NUM_REGS, 16, number of registers; legal indices 0..NUM_REGS-1; must satisfy 2 <= NUM_REGS <= 2^ADDR_WIDTH
- WAIT_CYCLES, 2, wait states inserted per transfer (0..15)
- ID_VALUE, 16'hA5B0, constant returned by register 0

Ports:
- HCLK  input  1  clock; all state changes on rising edge
- HRESETn  input  1  reset; asynchronous assert, active-low
- PSELx  input  1  slave select from APB master
- PENABLE  input  1  access-phase strobe
- PWRITE  input  1  1 = write, 0 = read
- PADDR  input  ADDR_WIDTH  register index
- PWDATA  input  DATA_WIDTH  write data
- PRDATA  output  DATA_WIDTH  read data; valid only while PREADY=1 on a read
- PREADY  output  1  transfer completion
- PSLVERR  output  1  transfer error; valid only while PREADY=1

Behaviour:
- Clock/reset: HRESETn is asynchronous, active-low; clock is HCLK.
- Reset values:
  - state IDLE, wait counter 0, latched address/write/data 0.
  - PRDATA 0, PREADY 0, PSLVERR 0.
  - reg[0] = ID_VALUE; reg[1..NUM_REGS-1] = 0.
- FSM states: IDLE, SETUP, ACCESS.
- IDLE:
  - PSELx=1 & PENABLE=0 -> SETUP.
  - Latch PADDR, PWRITE, PWDATA on that edge.
  - PENABLE=1 without a prior setup cycle is ignored; stay IDLE.
- SETUP (one cycle):
  - PSELx=1 & PENABLE=1 -> ACCESS, counter cleared to 0.
  - PSELx=0 -> IDLE (aborted, no effect).
- ACCESS:
  - PREADY = (counter == WAIT_CYCLES), combinational from state/counter.
  - Counter increments each ACCESS cycle while PREADY=0.
  - WAIT_CYCLES=0 gives PREADY on the first PENABLE cycle; WAIT_CYCLES=2 gives PREADY on the third.
- Completion: at the edge with PSELx & PENABLE & PREADY:
  - Legal write: reg[latched addr] <= latched data.
  - Next state is SETUP if PSELx=1 & PENABLE=0 in the following cycle; otherwise IDLE.
  - Back-to-back transfers therefore run with no idle cycle.
- Address decode on the latched address (PADDR changes during ACCESS are ignored):
  - Legal: idx < NUM_REGS, and not (write & idx==0).
  - Error: PSLVERR=1 together with PREADY; register file unchanged; PRDATA=0.
- PRDATA:
  - Legal read: reg[idx] while PREADY=1.
  - Any other cycle: 0.
- Write data source: latched PWDATA from the setup edge, not live PWDATA.
- Abort: PSELx deasserted during ACCESS before PREADY -> IDLE; no write; PREADY/PSLVERR stay 0.
- Reset mid-transfer: immediate return to reset values; the pending write is discarded.
- Read-after-write to the same register in the next transfer returns the new value.
- No other register side effects (no clear-on-read).

Test Plan:
1. Reset, then read idx 0 with WAIT_CYCLES=2 -> PREADY high on the 3rd PENABLE cycle; PRDATA=16'hA5B0; PSLVERR=0.
2. Write 16'h1234 to idx 5, then read idx 5 -> PRDATA=16'h1234. Read idx 6 -> PRDATA=0.
3. Write 16'hFFFF to idx 0 -> PSLVERR=1 with PREADY; subsequent read of idx 0 returns 16'hA5B0. Read idx 16 (NUM_REGS=16) -> PSLVERR=1, PRDATA=0.
4. Back-to-back: write idx 3=16'h00AA, then immediately (SETUP in the next cycle) read idx 3 -> 16'h00AA; no idle cycle required. Also check that changing PWDATA/PADDR during ACCESS has no effect.
5. Abort and reset:
   - Drop PSELx in the 2nd wait cycle of a write to idx 7 -> idx 7 remains 0; FSM returns to IDLE.
   - Assert HRESETn=0 mid-ACCESS -> PREADY=0 immediately; all registers return to reset values.
6. WAIT_CYCLES=0 instance: PREADY=1 on the first PENABLE cycle. PENABLE pulsed without a setup phase -> no PREADY; FSM stays IDLE.

Source files
------------

// File: rtl/apb_slave_regfile.sv
// APB register-file responder.
// A bank of NUM_REGS registers behind the APB side of the AHB-to-APB bridge.
// Register 0 is a read-only ID. Every transfer gets WAIT_CYCLES wait states
// through PREADY. PSLVERR flags an out-of-range index or a write to the ID.
module apb_slave_regfile #(
    parameter int                    DATA_WIDTH  = 16,
    parameter int                    ADDR_WIDTH  = 8,
    parameter int                    NUM_REGS    = 16,
    parameter int                    WAIT_CYCLES = 2,
    parameter logic [DATA_WIDTH-1:0] ID_VALUE    = 16'hA5B0
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    input  logic                  PSELx,
    input  logic                  PENABLE,
    input  logic                  PWRITE,
    input  logic [ADDR_WIDTH-1:0] PADDR,
    input  logic [DATA_WIDTH-1:0] PWDATA,
    output logic [DATA_WIDTH-1:0] PRDATA,
    output logic                  PREADY,
    output logic                  PSLVERR
);

    localparam int         IDX_W    = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [3:0] WAIT_LIM = 4'(WAIT_CYCLES);

    // SETUP covers the first PENABLE cycle after the setup edge.
    // ACCESS covers the wait cycles that follow it.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    state_t                  state, state_nxt;
    logic [3:0]              wait_cnt, wait_cnt_nxt;
    logic                    latch_en;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic                    write_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [IDX_W-1:0]        idx;
    logic                    in_range;
    logic                    legal;
    logic                    ready;
    logic                    do_write;
    logic [DATA_WIDTH-1:0]   regs [NUM_REGS];

    // Decode the latched transfer only. PADDR/PWRITE changes after the setup edge are ignored.
    assign idx      = addr_q[IDX_W-1:0];
    assign in_range = (32'(addr_q) < NUM_REGS);
    assign legal    = in_range && !(write_q && (addr_q == '0));

    // The count of elapsed enable cycles reaches the programmed wait count.
    assign ready    = (state != IDLE) && PSELx && PENABLE && (wait_cnt == WAIT_LIM);
    assign do_write = ready && write_q && legal;

    assign PREADY   = ready;
    assign PSLVERR  = ready && !legal;
    assign PRDATA   = (ready && !write_q && legal) ? regs[idx] : '0;

    // State and wait-counter registers.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
        if (!HRESETn) begin
            state    <= IDLE;
            wait_cnt <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
        end
    end

    // Next-state and counter logic.
    always_comb begin
        // NOTE: defaults first, so no path through the case leaves a signal unassigned (no latch).
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        latch_en     = 1'b0;
        case (state)
            IDLE: begin
                // An enable without a preceding setup cycle is ignored.
                if (PSELx && !PENABLE) begin
                    state_nxt    = SETUP;
                    wait_cnt_nxt = '0;
                    latch_en     = 1'b1;
                end
            end
            SETUP, ACCESS: begin
                if (!PSELx) begin
                    // Abort: back to idle with no register update.
                    state_nxt = IDLE;
                end else if (PENABLE) begin
                    if (ready) begin
                        // A following setup cycle is picked up from IDLE with no gap.
                        state_nxt = IDLE;
                    end else begin
                        state_nxt    = ACCESS;
                        wait_cnt_nxt = wait_cnt + 4'd1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Capture address, direction and write data on the setup edge.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            addr_q  <= '0;
            write_q <= 1'b0;
            wdata_q <= '0;
        end else if (latch_en) begin
            addr_q  <= PADDR;
            write_q <= PWRITE;
            wdata_q <= PWDATA;
        end
    end

    // Register bank. Entry 0 is held at ID_VALUE because a write to it is never legal.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        // NOTE: this array is reset on purpose, because software expects known zeros after reset.
        // Use flops here, not a RAM macro.
        if (!HRESETn) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= (i == 0) ? ID_VALUE : '0;
            end
        end else if (do_write) begin
            regs[idx] <= wdata_q;
        end
    end

endmodule

// File: tb/tb_apb_slave_regfile.sv
// Directed testbench for apb_slave_regfile.
// It uses two instances: WAIT_CYCLES=2 (main) and WAIT_CYCLES=0.
module tb_apb_slave_regfile;

    logic        HCLK = 1'b0;
    logic        HRESETn;
    logic        psel2, psel0;
    logic        PENABLE, PWRITE;
    logic [7:0]  PADDR;
    logic [15:0] PWDATA;
    logic [15:0] prdata2, prdata0;
    logic        pready2, pready0, pslverr2, pslverr0;
    bit          sel0;

    int vectors     = 0;
    int miscompares = 0;

    always #5 HCLK = ~HCLK;

    apb_slave_regfile #(.WAIT_CYCLES(2)) dut2 (
        .HCLK(HCLK), .HRESETn(HRESETn), .PSELx(psel2), .PENABLE(PENABLE),
        .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
        .PRDATA(prdata2), .PREADY(pready2), .PSLVERR(pslverr2)
    );

    apb_slave_regfile #(.WAIT_CYCLES(0)) dut0 (
        .HCLK(HCLK), .HRESETn(HRESETn), .PSELx(psel0), .PENABLE(PENABLE),
        .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
        .PRDATA(prdata0), .PREADY(pready0), .PSLVERR(pslverr0)
    );

    logic        b_ready, b_err;
    logic [15:0] b_rdata;
    assign b_ready = sel0 ? pready0  : pready2;
    assign b_err   = sel0 ? pslverr0 : pslverr2;
    assign b_rdata = sel0 ? prdata0  : prdata2;

    // One APB transfer on the selected instance.
    // It returns after sampling the completion cycle; the bus is left driven so a
    // following call runs back-to-back. cyc is the enable cycle that saw
    // PREADY, or -1 on timeout.
    task automatic apb_xfer(input logic wr, input logic [7:0] a, input logic [15:0] d,
                            input bit scramble, output logic [15:0] rd,
                            output logic err, output int cyc);
        @(negedge HCLK);
        if (sel0) psel0 = 1'b1; else psel2 = 1'b1;
        PENABLE = 1'b0; PWRITE = wr; PADDR = a; PWDATA = d;
        @(negedge HCLK);
        PENABLE = 1'b1;
        cyc = -1; rd = '0; err = 1'b0;
        for (int n = 1; n <= 20; n++) begin
            #1;
            if (b_ready) begin
                rd = b_rdata; err = b_err; cyc = n;
                break;
            end
            @(negedge HCLK);
            if (scramble) begin
                PADDR  = 8'h09;
                PWDATA = 16'hDEAD;
            end
        end
    endtask

    task automatic bus_idle();
        @(negedge HCLK);
        psel2 = 1'b0; psel0 = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge HCLK);
        HRESETn = 1'b0;
        repeat (2) @(negedge HCLK);
        HRESETn = 1'b1;
    endtask

    task automatic test_reset();
        logic [15:0] rd; logic err; int cyc;
        psel2 = 0; psel0 = 0; PENABLE = 0; PWRITE = 0; PADDR = 0; PWDATA = 0; sel0 = 0;
        HRESETn = 1'b0;
        #2;
        vectors++;
        if (pready2 !== 1'b0 || pslverr2 !== 1'b0 || prdata2 !== 16'h0000 ||
            pready0 !== 1'b0 || pslverr0 !== 1'b0 || prdata0 !== 16'h0000) begin
            miscompares++;
            $display("FAIL reset_outputs: got rdy2=%b err2=%b rd2=%h rdy0=%b err0=%b rd0=%h, want all 0",
                     pready2, pslverr2, prdata2, pready0, pslverr0, prdata0);
        end
        repeat (2) @(negedge HCLK);
        HRESETn = 1'b1;
        apb_xfer(1'b0, 8'd0, 16'h0, 1'b0, rd, err, cyc);
        vectors++;
        if (cyc !== 3 || rd !== 16'hA5B0 || err !== 1'b0) begin
            miscompares++;
            $display("FAIL read_id_wait2: got cyc=%0d rd=%h err=%b, want cyc=3 rd=a5b0 err=0", cyc, rd, err);
        end
        bus_idle();
        #1;
        vectors++;
        if (pready2 !== 1'b0 || prdata2 !== 16'h0000) begin
            miscompares++;
            $display("FAIL idle_outputs: got rdy=%b rd=%h, want 0/0000", pready2, prdata2);
        end
    endtask

    task automatic test_write_read();
        logic [15:0] rd; logic err; int cyc;
        apb_xfer(1'b1, 8'd5, 16'h1234, 1'b0, rd, err, cyc);
        vectors++;
        if (cyc !== 3 || err !== 1'b0 || rd !== 16'h0000) begin
            miscompares++;
            $display("FAIL write_5: got cyc=%0d err=%b rd=%h, want cyc=3 err=0 rd=0000", cyc, err, rd);
        end
        bus_idle();
        apb_xfer(1'b0, 8'd5, 16'h0, 1'b0, rd, err, cyc);
        vectors++;
        if (cyc !== 3 || rd !== 16'h1234 || err !== 1'b0) begin
            miscompares++;
            $display("FAIL read_5: got cyc=%0d rd=%h err=%b, want cyc=3 rd=1234 err=0", cyc, rd, err);
        end
        bus_idle();
        apb_xfer(1'b0, 8'd6, 16'h0, 1'b0, rd, err, cyc);
        vectors++;
        if (cyc !== 3 || rd !== 16'h0000 || err !== 1'b0) begin
            miscompares++;
            $display("FAIL read_6: got cyc=%0d rd=%h err=%b, want cyc=3 rd=0000 err=0", cyc, rd, err);
        end
        bus_idle();
    endtask

    task automatic test_illegal();
        logic [15:0] rd; logic err; int cyc;
        apb_xfer(1'b1, 8'd0, 16'hFFFF, 1'b0, rd, err, cyc);
        vectors++;
        if (cyc !== 3 || err !== 1'b1) begin
            miscompares++;
            $display("FAIL write_id_err: got cyc=%0d err=%b, want cyc=3 err=1", cyc, err);
        end
        bus_idle();
        apb_xfer(1'b0, 8'd0, 16'h0, 1'b0, rd, err, cyc);
        vectors++;
        if (rd !== 16'hA5B0 || err !== 1'b0) begin
            miscompares++;
            $display("FAIL id_unchanged: got rd=%h err=%b, want rd=a5b0 err=0", rd, err);
        end
        bus_idle();
        apb_xfer(1'b0, 8'd16, 16'h0, 1'b0, rd, err, cyc);
        vectors++;
        if (cyc !== 3 || rd !== 16'h0000 || err !== 1'b1) begin
            miscompares++;
            $display("FAIL read_oob: got cyc=%0d rd=%h err=%b, want cyc=3 rd=0000 err=1", cyc, rd, err);
        end
        bus_idle();
        apb_xfer(1'b1, 8'd200, 16'h5555, 1'b0, rd, err, cyc);
        vectors++;
        if (err !== 1'b1) begin
            miscompares++;
            $display("FAIL write_oob: got err=%b, want 1", err);
        end
        bus_idle();
        apb_xfer(1'b0, 8'd15, 16'h0, 1'b0, rd, err, cyc);
        vectors++;
        if (rd !== 16'h0000 || err !== 1'b0) begin
            miscompares++;
            $display("FAIL read_last_reg: got rd=%h err=%b, want rd=0000 err=0", rd, err);
        end
        bus_idle();
    endtask

    task automatic test_back_to_back();
        logic [15:0] rd; logic err; int cyc;
        // The write changes PADDR/PWDATA during its wait cycles; the latched values must win.
        apb_xfer(1'b1, 8'd3, 16'h00AA, 1'b1, rd, err, cyc);
        vectors++;
        if (cyc !== 3 || err !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_write: got cyc=%0d err=%b, want cyc=3 err=0", cyc, err);
        end
        apb_xfer(1'b0, 8'd3, 16'h0, 1'b0, rd, err, cyc);
        vectors++;
        if (cyc !== 3 || rd !== 16'h00AA || err !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_read_3: got cyc=%0d rd=%h err=%b, want cyc=3 rd=00aa err=0", cyc, rd, err);
        end
        apb_xfer(1'b0, 8'd9, 16'h0, 1'b0, rd, err, cyc);
        vectors++;
        if (rd !== 16'h0000 || err !== 1'b0) begin
            miscompares++;
            $display("FAIL scramble_no_effect: got rd=%h err=%b, want rd=0000 err=0", rd, err);
        end
        bus_idle();
    endtask

    task automatic test_abort();
        logic [15:0] rd; logic err; int cyc;
        @(negedge HCLK);
        psel2 = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 8'd7; PWDATA = 16'h7777;
        @(negedge HCLK);
        PENABLE = 1'b1;
        @(negedge HCLK);
        psel2 = 1'b0;
        #1;
        vectors++;
        if (pready2 !== 1'b0 || pslverr2 !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_outputs: got rdy=%b err=%b, want 0/0", pready2, pslverr2);
        end
        bus_idle();
        apb_xfer(1'b0, 8'd7, 16'h0, 1'b0, rd, err, cyc);
        vectors++;
        if (cyc !== 3 || rd !== 16'h0000 || err !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_no_write: got cyc=%0d rd=%h err=%b, want cyc=3 rd=0000 err=0", cyc, rd, err);
        end
        bus_idle();
    endtask

    task automatic test_reset_mid_access();
        logic [15:0] rd; logic err; int cyc;
        @(negedge HCLK);
        psel2 = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 8'd4; PWDATA = 16'h4444;
        @(negedge HCLK);
        PENABLE = 1'b1;
        repeat (2) @(negedge HCLK);
        #1;
        vectors++;
        if (pready2 !== 1'b1) begin
            miscompares++;
            $display("FAIL pre_reset_ready: got rdy=%b, want 1", pready2);
        end
        HRESETn = 1'b0;
        #1;
        vectors++;
        if (pready2 !== 1'b0 || pslverr2 !== 1'b0 || prdata2 !== 16'h0000) begin
            miscompares++;
            $display("FAIL reset_mid_access: got rdy=%b err=%b rd=%h, want 0/0/0000", pready2, pslverr2, prdata2);
        end
        bus_idle();
        @(negedge HCLK);
        HRESETn = 1'b1;
        apb_xfer(1'b0, 8'd4, 16'h0, 1'b0, rd, err, cyc);
        vectors++;
        if (cyc !== 3 || rd !== 16'h0000) begin
            miscompares++;
            $display("FAIL reset_discard_write: got cyc=%0d rd=%h, want cyc=3 rd=0000", cyc, rd);
        end
        apb_xfer(1'b0, 8'd5, 16'h0, 1'b0, rd, err, cyc);
        vectors++;
        if (rd !== 16'h0000) begin
            miscompares++;
            $display("FAIL reset_clears_5: got rd=%h, want 0000", rd);
        end
        apb_xfer(1'b0, 8'd3, 16'h0, 1'b0, rd, err, cyc);
        vectors++;
        if (rd !== 16'h0000) begin
            miscompares++;
            $display("FAIL reset_clears_3: got rd=%h, want 0000", rd);
        end
        apb_xfer(1'b0, 8'd0, 16'h0, 1'b0, rd, err, cyc);
        vectors++;
        if (rd !== 16'hA5B0) begin
            miscompares++;
            $display("FAIL reset_id: got rd=%h, want a5b0", rd);
        end
        bus_idle();
    endtask

    task automatic test_wait0();
        logic [15:0] rd; logic err; int cyc;
        sel0 = 1'b1;
        apb_xfer(1'b0, 8'd0, 16'h0, 1'b0, rd, err, cyc);
        vectors++;
        if (cyc !== 1 || rd !== 16'hA5B0 || err !== 1'b0) begin
            miscompares++;
            $display("FAIL wait0_read_id: got cyc=%0d rd=%h err=%b, want cyc=1 rd=a5b0 err=0", cyc, rd, err);
        end
        apb_xfer(1'b1, 8'd2, 16'hBEEF, 1'b0, rd, err, cyc);
        vectors++;
        if (cyc !== 1 || err !== 1'b0) begin
            miscompares++;
            $display("FAIL wait0_write: got cyc=%0d err=%b, want cyc=1 err=0", cyc, err);
        end
        apb_xfer(1'b0, 8'd2, 16'h0, 1'b0, rd, err, cyc);
        vectors++;
        if (cyc !== 1 || rd !== 16'hBEEF) begin
            miscompares++;
            $display("FAIL wait0_read_back: got cyc=%0d rd=%h, want cyc=1 rd=beef", cyc, rd);
        end
        bus_idle();
    endtask

    task automatic test_penable_no_setup();
        logic [15:0] rd; logic err; int cyc;
        int seen;
        sel0 = 1'b1;
        seen = 0;
        @(negedge HCLK);
        psel0 = 1'b1; PENABLE = 1'b1; PWRITE = 1'b0; PADDR = 8'd0;
        for (int n = 0; n < 3; n++) begin
            #1;
            if (pready0 !== 1'b0) seen++;
            @(negedge HCLK);
        end
        vectors++;
        if (seen != 0) begin
            miscompares++;
            $display("FAIL no_setup_ready: got %0d ready cycles, want 0", seen);
        end
        psel0 = 1'b0; PENABLE = 1'b0;
        apb_xfer(1'b0, 8'd0, 16'h0, 1'b0, rd, err, cyc);
        vectors++;
        if (cyc !== 1 || rd !== 16'hA5B0) begin
            miscompares++;
            $display("FAIL no_setup_idle: got cyc=%0d rd=%h, want cyc=1 rd=a5b0", cyc, rd);
        end
        bus_idle();
        sel0 = 1'b0;
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_illegal();
        test_back_to_back();
        test_abort();
        test_reset_mid_access();
        test_wait0();
        test_penable_no_setup();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
